// File: rtl/scarv_cop_mem_arb_pkg.sv
// rtl/scarv_cop_mem_arb_pkg.sv - shared grant encodings and port indices for the memory arbiter
package scarv_cop_mem_arb_pkg;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_P0   = 2'b01;
   localparam logic [1:0] GNT_P1   = 2'b10;

   localparam int unsigned PORT_0 = 0;
   localparam int unsigned PORT_1 = 1;

endpackage

// File: rtl/scarv_rr_arb2.sv
// rtl/scarv_rr_arb2.sv - two-requester pick, round-robin or fixed priority, one-hot grant
module scarv_rr_arb2
   import scarv_cop_mem_arb_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic [1:0] req_i,
   input  logic       rr_last_i,
   output logic [1:0] gnt_o
);

   // Sole requester wins; a tie goes to the port that did not win last (or port 0 when fixed).
   always_comb begin
      gnt_o = GNT_NONE;
      case (req_i)
         2'b01:   gnt_o = GNT_P0;
         2'b10:   gnt_o = GNT_P1;
         2'b11:   gnt_o = (FIXED_PRIO || rr_last_i) ? GNT_P0 : GNT_P1;
         default: gnt_o = GNT_NONE;
      endcase
   end

endmodule

// File: rtl/scarv_cop_mem_arb.sv
// rtl/scarv_cop_mem_arb.sv - shares one memory bus between the host data port and the coprocessor port
module scarv_cop_mem_arb
   import scarv_cop_mem_arb_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        g_clk,
   input  logic        g_resetn,

   input  logic        m0_cen,
   input  logic        m0_wen,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_ben,
   output logic [31:0] m0_rdata,
   output logic        m0_stall,
   output logic        m0_error,

   input  logic        m1_cen,
   input  logic        m1_wen,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_ben,
   output logic [31:0] m1_rdata,
   output logic        m1_stall,
   output logic        m1_error,

   output logic        mem_cen,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_ben,
   input  logic [31:0] mem_rdata,
   input  logic        mem_stall,
   input  logic        mem_error
);

   logic [1:0] gnt_q, gnt_d;
   logic       hold_q, hold_d;
   logic       rr_last_q, rr_last_d;
   logic       rsp_pend_q, rsp_pend_d;
   logic       rsp_own_q, rsp_own_d;

   logic [1:0] req;
   logic [1:0] arb_gnt;
   logic       hold_valid;
   logic       accept;
   logic       rsp_done;

   assign req[PORT_0] = m0_cen;
   assign req[PORT_1] = m1_cen;

   scarv_rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .req_i     (req),
      .rr_last_i (rr_last_q),
      .gnt_o     (arb_gnt)
   );

   // A stalled grant sticks only while its port keeps requesting; a dropped cen falls back to arbitration.
   assign hold_valid = hold_q && ((gnt_q & req) != GNT_NONE);
   assign gnt_d      = hold_valid ? gnt_q : arb_gnt;

   assign accept   = mem_cen && !mem_stall;
   assign rsp_done = rsp_pend_q && !mem_stall;

   // Request mux toward memory; everything idles at zero without a grant.
   always_comb begin
      mem_cen   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_ben   = 4'h0;
      if (gnt_d == GNT_P0) begin
         mem_cen   = 1'b1;
         mem_wen   = m0_wen;
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_ben   = m0_ben;
      end else if (gnt_d == GNT_P1) begin
         mem_cen   = 1'b1;
         mem_wen   = m1_wen;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_ben   = m1_ben;
      end
   end

   // Response side: data is broadcast, error is steered to the owner of the completing response.
   always_comb begin
      m0_rdata = mem_rdata;
      m1_rdata = mem_rdata;
      m0_error = rsp_done && !rsp_own_q && mem_error;
      m1_error = rsp_done &&  rsp_own_q && mem_error;
      m0_stall = ((gnt_d[PORT_0] && m0_cen) || (rsp_pend_q && !rsp_own_q)) ? mem_stall : m0_cen;
      m1_stall = ((gnt_d[PORT_1] && m1_cen) || (rsp_pend_q &&  rsp_own_q)) ? mem_stall : m1_cen;
   end

   // Next-state for hold, round-robin history and the one-deep response tracker.
   always_comb begin
      hold_d     = mem_cen && mem_stall;
      rr_last_d  = rr_last_q;
      rsp_pend_d = rsp_pend_q;
      rsp_own_d  = rsp_own_q;
      if (rsp_done) begin
         rsp_pend_d = 1'b0;
      end
      if (accept) begin
         rsp_pend_d = 1'b1;
         rsp_own_d  = gnt_d[PORT_1];
         rr_last_d  = gnt_d[PORT_1];
      end
   end

   // State registers; rr_last resets to port 1 so port 0 wins the first tie.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         gnt_q      <= GNT_NONE;
         hold_q     <= 1'b0;
         rr_last_q  <= 1'b1;
         rsp_pend_q <= 1'b0;
         rsp_own_q  <= 1'b0;
      end else begin
         gnt_q      <= gnt_d;
         hold_q     <= hold_d;
         rr_last_q  <= rr_last_d;
         rsp_pend_q <= rsp_pend_d;
         rsp_own_q  <= rsp_own_d;
      end
   end

endmodule

// File: tb/tb_scarv_cop_mem_arb.sv
// tb/tb_scarv_cop_mem_arb.sv - directed self-checking bench for the two-port memory arbiter
module tb_scarv_cop_mem_arb;

   logic        g_clk = 1'b0;
   logic        g_resetn = 1'b0;

   logic        m0_cen, m0_wen, m1_cen, m1_wen;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_ben, m1_ben;
   logic [31:0] mem_rdata;
   logic        mem_stall, mem_error;

   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
   logic        m0_stall, m0_error, m1_stall, m1_error, mem_cen, mem_wen;
   logic [3:0]  mem_ben;

   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata;
   logic        fp_m0_stall, fp_m0_error, fp_m1_stall, fp_m1_error, fp_mem_cen, fp_mem_wen;
   logic [3:0]  fp_mem_ben;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 g_clk = ~g_clk;

   scarv_cop_mem_arb #(.FIXED_PRIO(1'b0)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .m0_cen(m0_cen), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ben(m0_ben),
      .m0_rdata(m0_rdata), .m0_stall(m0_stall), .m0_error(m0_error),
      .m1_cen(m1_cen), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ben(m1_ben),
      .m1_rdata(m1_rdata), .m1_stall(m1_stall), .m1_error(m1_error),
      .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
      .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error)
   );

   scarv_cop_mem_arb #(.FIXED_PRIO(1'b1)) dut_fp (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .m0_cen(m0_cen), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ben(m0_ben),
      .m0_rdata(fp_m0_rdata), .m0_stall(fp_m0_stall), .m0_error(fp_m0_error),
      .m1_cen(m1_cen), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ben(m1_ben),
      .m1_rdata(fp_m1_rdata), .m1_stall(fp_m1_stall), .m1_error(fp_m1_error),
      .mem_cen(fp_mem_cen), .mem_wen(fp_mem_wen), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
      .mem_ben(fp_mem_ben),
      .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic idle();
      m0_cen = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0; m0_ben = 0;
      m1_cen = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0; m1_ben = 0;
      mem_rdata = 0; mem_stall = 0; mem_error = 0;
   endtask

   task automatic do_reset();
      @(negedge g_clk);
      g_resetn = 0;
      idle();
      repeat (2) @(negedge g_clk);
      g_resetn = 1;
   endtask

   initial begin
      idle();

      // Reset values: request fields present but no cen
      do_reset();
      @(negedge g_clk);
      m0_addr = 32'hFFFF_0000; m0_wdata = 32'h1234_5678; m0_ben = 4'hF; m0_wen = 1;
      #1;
      check("rst_mem_cen",   {31'b0, mem_cen},  32'h0);
      check("rst_mem_addr",  mem_addr,          32'h0);
      check("rst_mem_wdata", mem_wdata,         32'h0);
      check("rst_mem_ben",   {28'b0, mem_ben},  32'h0);
      check("rst_m0_stall",  {31'b0, m0_stall}, 32'h0);
      check("rst_m1_stall",  {31'b0, m1_stall}, 32'h0);
      check("rst_m0_error",  {31'b0, m0_error}, 32'h0);
      check("rst_rr_last",   {31'b0, dut.rr_last_q}, 32'h1);

      // Single read
      do_reset();
      @(negedge g_clk);
      m0_cen = 1; m0_addr = 32'h0000_1000;
      #1;
      check("rd_mem_addr", mem_addr,          32'h0000_1000);
      check("rd_mem_cen",  {31'b0, mem_cen},  32'h1);
      check("rd_m0_stall", {31'b0, m0_stall}, 32'h0);
      @(negedge g_clk);
      idle(); mem_rdata = 32'hDEAD_BEEF;
      #1;
      check("rd_m0_rdata", m0_rdata,          32'hDEAD_BEEF);
      check("rd_m0_stall2",{31'b0, m0_stall}, 32'h0);
      check("rd_m0_error", {31'b0, m0_error}, 32'h0);

      // Tie after reset, round-robin vs fixed priority
      do_reset();
      @(negedge g_clk);
      m0_cen = 1; m0_addr = 32'h100;
      m1_cen = 1; m1_addr = 32'h200; m1_wen = 1; m1_wdata = 32'hCAFE_0001; m1_ben = 4'h3;
      #1;
      check("tie_mem_addr",    mem_addr,             32'h100);
      check("tie_m1_stall",    {31'b0, m1_stall},    32'h1);
      check("tie_fp_mem_addr", fp_mem_addr,          32'h100);
      @(negedge g_clk);
      #1;
      check("tie2_mem_addr",    mem_addr,            32'h200);
      check("tie2_mem_wen",     {31'b0, mem_wen},    32'h1);
      check("tie2_mem_wdata",   mem_wdata,           32'hCAFE_0001);
      check("tie2_mem_ben",     {28'b0, mem_ben},    32'h3);
      check("tie2_fp_mem_addr", fp_mem_addr,         32'h100);
      check("tie2_fp_m1_stall", {31'b0, fp_m1_stall},32'h1);

      // Stall hold on port 1 while port 0 starts requesting
      do_reset();
      @(negedge g_clk);
      m1_cen = 1; m1_addr = 32'h300; mem_stall = 1;
      #1;
      check("hold1_mem_addr", mem_addr,          32'h300);
      check("hold1_m1_stall", {31'b0, m1_stall}, 32'h1);
      @(negedge g_clk);
      m0_cen = 1; m0_addr = 32'h400;
      #1;
      check("hold2_mem_addr", mem_addr,          32'h300);
      check("hold2_m0_stall", {31'b0, m0_stall}, 32'h1);
      @(negedge g_clk);
      #1;
      check("hold3_mem_addr", mem_addr,          32'h300);
      check("hold3_m0_stall", {31'b0, m0_stall}, 32'h1);
      @(negedge g_clk);
      mem_stall = 0;
      #1;
      check("hold4_mem_addr", mem_addr,          32'h300);
      check("hold4_m1_stall", {31'b0, m1_stall}, 32'h0);
      check("hold4_m0_stall", {31'b0, m0_stall}, 32'h1);
      @(negedge g_clk);
      m1_cen = 0;
      #1;
      check("hold5_mem_addr", mem_addr,          32'h400);
      check("hold5_m0_stall", {31'b0, m0_stall}, 32'h0);

      // Overlapping requests and error routing
      do_reset();
      @(negedge g_clk);
      m0_cen = 1; m0_addr = 32'h10;
      #1;
      check("ovl_k_mem_addr", mem_addr, 32'h10);
      @(negedge g_clk);
      m0_cen = 0; m1_cen = 1; m1_addr = 32'h20; mem_error = 1;
      #1;
      check("ovl_k1_mem_addr", mem_addr,          32'h20);
      check("ovl_k1_m0_error", {31'b0, m0_error}, 32'h1);
      check("ovl_k1_m1_error", {31'b0, m1_error}, 32'h0);
      @(negedge g_clk);
      idle(); mem_error = 1;
      #1;
      check("ovl_k2_m1_error", {31'b0, m1_error}, 32'h1);
      check("ovl_k2_m0_error", {31'b0, m0_error}, 32'h0);
      @(negedge g_clk);
      #1;
      check("ovl_idle_m0_error", {31'b0, m0_error}, 32'h0);
      check("ovl_idle_m1_error", {31'b0, m1_error}, 32'h0);

      // Stall during a pending response
      do_reset();
      @(negedge g_clk);
      m0_cen = 1; m0_addr = 32'h30;
      @(negedge g_clk);
      m0_cen = 0; m1_cen = 1; m1_addr = 32'h40; mem_stall = 1;
      #1;
      check("sdr1_m0_stall", {31'b0, m0_stall}, 32'h1);
      check("sdr1_m1_stall", {31'b0, m1_stall}, 32'h1);
      @(negedge g_clk);
      mem_stall = 0; mem_error = 1;
      #1;
      check("sdr2_m0_error", {31'b0, m0_error}, 32'h1);
      check("sdr2_m1_stall", {31'b0, m1_stall}, 32'h0);
      check("sdr2_mem_addr", mem_addr,          32'h40);
      @(negedge g_clk);
      idle(); mem_error = 1;
      #1;
      check("sdr3_m1_error", {31'b0, m1_error}, 32'h1);
      check("sdr3_m0_error", {31'b0, m0_error}, 32'h0);

      // Reset with a response outstanding
      do_reset();
      @(negedge g_clk);
      m0_cen = 1; m0_addr = 32'h50;
      @(negedge g_clk);
      g_resetn = 0; idle(); mem_error = 1;
      @(negedge g_clk);
      g_resetn = 1; mem_error = 1;
      #1;
      check("rmid_rsp_pend", {31'b0, dut.rsp_pend_q}, 32'h0);
      check("rmid_m0_error", {31'b0, m0_error},       32'h0);
      check("rmid_m1_error", {31'b0, m1_error},       32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
